// File: rtl/fp_normalize_pipe.sv
// Three-stage normalizer for an aligned two's-complement mantissa sum:
// magnitude capture, leading-one normalization, then round-to-nearest-even with exponent limits.
module fp_normalize_pipe #(
  parameter int EXP_W  = 11,
  parameter int FRAC_W = 52,
  parameter int SUM_W  = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [EXP_W-1:0]  iexp_max,
  input  logic [SUM_W-1:0]  isum,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              osign,
  output logic [EXP_W-1:0]  oexp,
  output logic [FRAC_W-1:0] ofrac,
  output logic              ozero,
  output logic              oovf,
  output logic              ounf
);

  localparam int H     = SUM_W - 5;
  localparam int POS_W = $clog2(SUM_W);
  localparam int EW    = EXP_W + 2;
  localparam int LSB   = SUM_W - 1 - FRAC_W;

  localparam logic [POS_W-1:0]     TOP_POS = POS_W'(SUM_W - 1);
  localparam logic signed [EW-1:0] H_E     = EW'(H);
  localparam logic signed [EW-1:0] E_MAX   = EW'((1 << EXP_W) - 1);

  logic s1_valid;
  logic s2_valid;
  logic s3_valid;
  logic s1_load;
  logic s2_load;
  logic s3_load;

  // A stage may load whenever it is empty or its contents move on this cycle.
  assign s3_load   = !s3_valid || out_ready;
  assign s2_load   = !s2_valid || s3_load;
  assign s1_load   = !s1_valid || s2_load;
  assign in_ready  = s1_load;
  assign out_valid = s3_valid;

  logic              s1_sign;
  logic [SUM_W-1:0]  s1_mag;
  logic [EXP_W-1:0]  s1_exp;
  logic [SUM_W-1:0]  in_mag;

  assign in_mag = isum[SUM_W-1] ? -isum : isum;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_mag   <= '0;
      s1_exp   <= '0;
    end else if (s1_load) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sign <= isum[SUM_W-1];
        s1_mag  <= in_mag;
        s1_exp  <= iexp_max;
      end
    end
  end

  logic [POS_W-1:0]     lead_pos;
  logic [POS_W-1:0]     shift_amt;
  logic [SUM_W-1:0]     norm;
  logic signed [EW-1:0] exp_adj;

  always_comb begin
    lead_pos = '0;
    for (int i = 0; i < SUM_W; i++) begin
      if (s1_mag[i]) lead_pos = POS_W'(i);
    end
  end

  assign shift_amt = TOP_POS - lead_pos;
  assign norm      = s1_mag << shift_amt;
  assign exp_adj   = $signed({{(EW-EXP_W){1'b0}}, s1_exp})
                   + $signed({{(EW-POS_W){1'b0}}, lead_pos}) - H_E;

  logic                 s2_sign;
  logic [SUM_W-2:0]     s2_norm;
  logic signed [EW-1:0] s2_exp;
  logic                 s2_zero;

  // After normalization the top bit is set for every nonzero magnitude, so it doubles as the zero test.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_sign  <= 1'b0;
      s2_norm  <= '0;
      s2_exp   <= '0;
      s2_zero  <= 1'b0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_sign <= s1_sign;
        s2_norm <= norm[SUM_W-2:0];
        s2_exp  <= exp_adj;
        s2_zero <= !norm[SUM_W-1];
      end
    end
  end

  logic                 rnd_lsb;
  logic                 rnd_guard;
  logic                 rnd_sticky;
  logic                 round_up;
  logic                 carry;
  logic [FRAC_W-1:0]    frac_rnd;
  logic signed [EW-1:0] exp_fin;

  assign rnd_lsb    = s2_norm[LSB];
  assign rnd_guard  = s2_norm[LSB-1];
  assign rnd_sticky = |s2_norm[LSB-2:0];
  assign round_up   = rnd_guard && (rnd_sticky || rnd_lsb);

  assign {carry, frac_rnd} = {1'b0, s2_norm[SUM_W-2:LSB]} + {{FRAC_W{1'b0}}, round_up};
  assign exp_fin = s2_exp + $signed({{(EW-1){1'b0}}, carry});

  logic              nx_sign;
  logic [EXP_W-1:0]  nx_exp;
  logic [FRAC_W-1:0] nx_frac;
  logic              nx_zero;
  logic              nx_ovf;
  logic              nx_unf;

  // Limit checks use the exponent after any rounding carry has been folded in.
  always_comb begin
    nx_sign = s2_sign;
    nx_exp  = exp_fin[EXP_W-1:0];
    nx_frac = frac_rnd;
    nx_zero = 1'b0;
    nx_ovf  = 1'b0;
    nx_unf  = 1'b0;
    if (s2_zero) begin
      nx_sign = 1'b0;
      nx_exp  = '0;
      nx_frac = '0;
      nx_zero = 1'b1;
    end else if (exp_fin >= E_MAX) begin
      nx_exp  = '1;
      nx_frac = '0;
      nx_ovf  = 1'b1;
    end else if (exp_fin[EW-1] || (exp_fin == '0)) begin
      nx_exp  = '0;
      nx_frac = '0;
      nx_zero = 1'b1;
      nx_unf  = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s3_valid <= 1'b0;
      osign    <= 1'b0;
      oexp     <= '0;
      ofrac    <= '0;
      ozero    <= 1'b0;
      oovf     <= 1'b0;
      ounf     <= 1'b0;
    end else if (s3_load) begin
      s3_valid <= s2_valid;
      if (s2_valid) begin
        osign <= nx_sign;
        oexp  <= nx_exp;
        ofrac <= nx_frac;
        ozero <= nx_zero;
        oovf  <= nx_ovf;
        ounf  <= nx_unf;
      end
    end
  end

endmodule

// File: tb/tb_fp_normalize_pipe.sv
// Bench for fp_normalize_pipe: directed corner vectors plus randomized traffic
// checked against an arithmetic quotient/remainder rounding model.
module tb_fp_normalize_pipe;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [10:0] iexp_max = '0;
  logic [63:0] isum = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        osign;
  logic [10:0] oexp;
  logic [51:0] ofrac;
  logic        ozero;
  logic        oovf;
  logic        ounf;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic        sign;
    logic [10:0] exp;
    logic [51:0] frac;
    logic        zero;
    logic        ovf;
    logic        unf;
  } res_t;

  res_t exp_q[$];

  fp_normalize_pipe #(.EXP_W(11), .FRAC_W(52), .SUM_W(64)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .iexp_max(iexp_max), .isum(isum), .out_valid(out_valid), .out_ready(out_ready),
    .osign(osign), .oexp(oexp), .ofrac(ofrac), .ozero(ozero), .oovf(oovf), .ounf(ounf)
  );

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got time limit reached, required normal completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // value = isum * 2^(iexp_max-59); mantissa rounded with integer quotient and remainder
  function automatic res_t ref_model(input logic [63:0] s, input logic [10:0] ie);
    res_t r;
    logic [63:0] m, q, rem, half;
    int p, e;
    r = '0;
    m = s[63] ? (64'd0 - s) : s;
    if (m == 64'd0) begin
      r.zero = 1'b1;
      return r;
    end
    p = 0;
    for (int i = 0; i < 64; i++) if ((m >> i) != 64'd0) p = i;
    if (p > 52) begin
      q    = m >> (p - 52);
      rem  = m - (q << (p - 52));
      half = 64'd1 << (p - 53);
      if (rem > half || (rem == half && q[0])) q = q + 64'd1;
    end else begin
      q = m << (52 - p);
    end
    e = int'(ie) + p - 59;
    if (q == (64'd1 << 53)) begin
      q = 64'd1 << 52;
      e = e + 1;
    end
    r.sign = s[63];
    if (e >= 2047) begin
      r.exp = 11'h7FF;
      r.ovf = 1'b1;
    end else if (e <= 0) begin
      r.zero = 1'b1;
      r.unf  = 1'b1;
    end else begin
      r.exp  = e[10:0];
      r.frac = q[51:0];
    end
    return r;
  endfunction

  function automatic res_t mk(input logic sg, input logic [10:0] ex, input logic [51:0] fr,
                              input logic zr, input logic ov, input logic un);
    res_t r;
    r = {sg, ex, fr, zr, ov, un};
    return r;
  endfunction

  function automatic res_t dut_out();
    res_t r;
    r = {osign, oexp, ofrac, ozero, oovf, ounf};
    return r;
  endfunction

  function automatic logic [63:0] rand_sum();
    logic [63:0] v;
    int sh;
    v  = {$urandom, $urandom};
    sh = $urandom_range(0, 63);
    v  = v >> sh;
    case ($urandom_range(0, 19))
      0: v = 64'h8000_0000_0000_0000;
      1: v = 64'd0;
      default: ;
    endcase
    if ($urandom_range(0, 1) == 1) v = 64'd0 - v;
    return v;
  endfunction

  function automatic logic [10:0] rand_exp();
    logic [10:0] v;
    case ($urandom_range(0, 3))
      0: v = 11'($urandom_range(0, 2047));
      1: v = 11'($urandom_range(0, 70));
      2: v = 11'($urandom_range(1980, 2047));
      default: v = 11'($urandom_range(900, 1150));
    endcase
    return v;
  endfunction

  // Drives one input into an empty pipe and reports the result and how many negedges it took.
  task automatic send_and_wait(input logic [63:0] s, input logic [10:0] ie,
                               output res_t got, output int lat);
    logic accepted;
    got = '0;
    lat = -1;
    accepted = 1'b0;
    @(negedge clock);
    in_valid = 1'b1; isum = s; iexp_max = ie; out_ready = 1'b1;
    for (int w = 0; w < 8 && !accepted; w++) begin
      #1 accepted = in_ready;
      @(posedge clock);
    end
    for (int c = 1; c <= 10 && accepted && lat < 0; c++) begin
      @(negedge clock);
      in_valid = 1'b0;
      if (out_valid) begin
        got = dut_out();
        lat = c;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    tests++;
    if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
    tests++;
    if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
    tests++;
    if (dut_out() !== res_t'(0)) begin fails++; $display("[TB] FAIL reset_outputs: got %h expected 0", dut_out()); end
    @(negedge clock);
    reset = 1'b0; out_ready = 1'b1;
    #1;
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++; $display("[TB] FAIL post_reset_idle: got in_ready=%b out_valid=%b expected 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_directed();
    logic [63:0] vs[20];
    logic [10:0] ve[20];
    res_t        vx[20];
    res_t        got;
    int          lat;
    vs[0]  = 64'h0800_0000_0000_0000; ve[0]  = 11'd1023; vx[0]  = mk(1'b0, 11'd1023, 52'd0, 1'b0, 1'b0, 1'b0);
    vs[1]  = 64'hF400_0000_0000_0000; ve[1]  = 11'd1023; vx[1]  = mk(1'b1, 11'd1023, 52'd1 << 51, 1'b0, 1'b0, 1'b0);
    vs[2]  = 64'h4000_0000_0000_0000; ve[2]  = 11'd1023; vx[2]  = mk(1'b0, 11'd1026, 52'd0, 1'b0, 1'b0, 1'b0);
    vs[3]  = 64'h0C00_0000_0000_0000; ve[3]  = 11'd1;    vx[3]  = mk(1'b0, 11'd1, 52'd1 << 51, 1'b0, 1'b0, 1'b0);
    vs[4]  = 64'h0400_0000_0000_0000; ve[4]  = 11'd1;    vx[4]  = mk(1'b0, 11'd0, 52'd0, 1'b1, 1'b0, 1'b1);
    vs[5]  = 64'h0800_0000_0000_0040; ve[5]  = 11'd1023; vx[5]  = mk(1'b0, 11'd1023, 52'd0, 1'b0, 1'b0, 1'b0);
    vs[6]  = 64'h0800_0000_0000_00C0; ve[6]  = 11'd1023; vx[6]  = mk(1'b0, 11'd1023, 52'd2, 1'b0, 1'b0, 1'b0);
    vs[7]  = 64'h0800_0000_0000_0041; ve[7]  = 11'd1023; vx[7]  = mk(1'b0, 11'd1023, 52'd1, 1'b0, 1'b0, 1'b0);
    vs[8]  = 64'h0800_0000_0000_0080; ve[8]  = 11'd1023; vx[8]  = mk(1'b0, 11'd1023, 52'd1, 1'b0, 1'b0, 1'b0);
    vs[9]  = 64'h0FFF_FFFF_FFFF_FFFF; ve[9]  = 11'd1023; vx[9]  = mk(1'b0, 11'd1024, 52'd0, 1'b0, 1'b0, 1'b0);
    vs[10] = 64'h1000_0000_0000_0000; ve[10] = 11'd2046; vx[10] = mk(1'b0, 11'd2047, 52'd0, 1'b0, 1'b1, 1'b0);
    vs[11] = 64'h0000_0000_0000_0000; ve[11] = 11'd500;  vx[11] = mk(1'b0, 11'd0, 52'd0, 1'b1, 1'b0, 1'b0);
    vs[12] = 64'h8000_0000_0000_0000; ve[12] = 11'd1000; vx[12] = mk(1'b1, 11'd1004, 52'd0, 1'b0, 1'b0, 1'b0);
    vs[13] = 64'hF000_0000_0000_0000; ve[13] = 11'd2046; vx[13] = mk(1'b1, 11'd2047, 52'd0, 1'b0, 1'b1, 1'b0);
    vs[14] = 64'hFC00_0000_0000_0000; ve[14] = 11'd1;    vx[14] = mk(1'b1, 11'd0, 52'd0, 1'b1, 1'b0, 1'b1);
    vs[15] = 64'h0FFF_FFFF_FFFF_FFFF; ve[15] = 11'd2046; vx[15] = mk(1'b0, 11'd2047, 52'd0, 1'b0, 1'b1, 1'b0);
    vs[16] = 64'h0800_0000_0000_0000; ve[16] = 11'd2046; vx[16] = mk(1'b0, 11'd2046, 52'd0, 1'b0, 1'b0, 1'b0);
    vs[17] = 64'h0800_0000_0000_0000; ve[17] = 11'd1;    vx[17] = mk(1'b0, 11'd1, 52'd0, 1'b0, 1'b0, 1'b0);
    vs[18] = 64'h0000_0000_0000_0001; ve[18] = 11'd1023; vx[18] = mk(1'b0, 11'd964, 52'd0, 1'b0, 1'b0, 1'b0);
    vs[19] = 64'hFFFF_FFFF_FFFF_FFFF; ve[19] = 11'd1023; vx[19] = mk(1'b1, 11'd964, 52'd0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) begin
      send_and_wait(vs[k], ve[k], got, lat);
      tests++;
      if (got !== vx[k]) begin
        fails++; $display("[TB] FAIL directed_%0d: got %h expected %h", k, got, vx[k]);
      end
      tests++;
      if (lat != 3) begin
        fails++; $display("[TB] FAIL latency_%0d: got %0d expected 3", k, lat);
      end
    end
  endtask

  task automatic test_back_to_back();
    int   issued, got, first, last;
    res_t e;
    issued = 0; got = 0; first = -1; last = -1;
    exp_q.delete();
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 30 && got < 16; cyc++) begin
      @(negedge clock);
      if (issued < 16) begin
        in_valid = 1'b1; isum = rand_sum(); iexp_max = rand_exp();
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (in_valid) begin
        tests++;
        if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL b2b_in_ready: got %b expected 1", in_ready); end
        if (in_ready) begin exp_q.push_back(ref_model(isum, iexp_max)); issued++; end
      end
      if (out_valid) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++; $display("[TB] FAIL b2b_extra: got out_valid=1 expected no pending result");
        end else begin
          e = exp_q.pop_front();
          if (dut_out() !== e) begin fails++; $display("[TB] FAIL b2b_data: got %h expected %h", dut_out(), e); end
        end
        got++;
        if (first < 0) first = cyc;
        last = cyc;
      end
    end
    @(negedge clock);
    in_valid = 1'b0;
    tests++;
    if (got != 16) begin fails++; $display("[TB] FAIL b2b_count: got %0d expected 16", got); end
    tests++;
    if (first != 3) begin fails++; $display("[TB] FAIL b2b_first: got cycle %0d expected 3", first); end
    tests++;
    if (last - first != 15) begin fails++; $display("[TB] FAIL b2b_throughput: got span %0d expected 15", last - first); end
  endtask

  task automatic test_backpressure();
    logic [63:0] bs[4];
    logic [10:0] be[4];
    res_t        snap, e;
    logic        snap_valid;
    int          acc, got, gap;
    for (int k = 0; k < 4; k++) begin bs[k] = rand_sum(); be[k] = rand_exp(); end
    exp_q.delete();
    acc = 0; snap_valid = 1'b0; snap = '0;
    out_ready = 1'b0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clock);
      if (acc < 4) begin in_valid = 1'b1; isum = bs[acc]; iexp_max = be[acc]; end
      else in_valid = 1'b0;
      #1;
      tests++;
      if (in_ready !== (cyc < 3)) begin
        fails++; $display("[TB] FAIL bp_in_ready_c%0d: got %b expected %b", cyc, in_ready, (cyc < 3));
      end
      if (out_valid) begin
        if (snap_valid) begin
          tests++;
          if (dut_out() !== snap) begin fails++; $display("[TB] FAIL bp_frozen: got %h expected %h", dut_out(), snap); end
        end else begin
          snap = dut_out(); snap_valid = 1'b1;
        end
      end
      if (in_valid && in_ready) begin exp_q.push_back(ref_model(isum, iexp_max)); acc++; end
    end
    tests++;
    if (acc != 3) begin fails++; $display("[TB] FAIL bp_accepted: got %0d expected 3", acc); end
    tests++;
    if (out_valid !== 1'b1) begin fails++; $display("[TB] FAIL bp_out_valid: got %b expected 1", out_valid); end
    got = 0; gap = 0;
    for (int cyc = 0; cyc < 12 && got < 4; cyc++) begin
      @(negedge clock);
      out_ready = 1'b1;
      if (acc < 4) begin in_valid = 1'b1; isum = bs[acc]; iexp_max = be[acc]; end
      else in_valid = 1'b0;
      #1;
      if (in_valid && in_ready) begin exp_q.push_back(ref_model(isum, iexp_max)); acc++; end
      if (out_valid) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++; $display("[TB] FAIL bp_extra: got out_valid=1 expected no pending result");
        end else begin
          e = exp_q.pop_front();
          if (dut_out() !== e) begin fails++; $display("[TB] FAIL bp_drain_%0d: got %h expected %h", got, dut_out(), e); end
        end
        got++;
      end else if (got > 0) begin
        gap++;
      end
    end
    @(negedge clock);
    in_valid = 1'b0;
    tests++;
    if (got != 4) begin fails++; $display("[TB] FAIL bp_drain_count: got %0d expected 4", got); end
    tests++;
    if (gap != 0) begin fails++; $display("[TB] FAIL bp_drain_gaps: got %0d expected 0", gap); end
  endtask

  task automatic test_random();
    int   issued;
    logic prev_stall;
    res_t snap, e;
    issued = 0; prev_stall = 1'b0; snap = '0;
    exp_q.delete();
    for (int cyc = 0; cyc < 5000 && (issued < 400 || exp_q.size() > 0); cyc++) begin
      @(negedge clock);
      if (issued < 400 && $urandom_range(0, 3) != 0) begin
        in_valid = 1'b1; isum = rand_sum(); iexp_max = rand_exp();
      end else begin
        in_valid = 1'b0;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (prev_stall) begin
        tests++;
        if (out_valid !== 1'b1 || dut_out() !== snap) begin
          fails++; $display("[TB] FAIL rand_hold: got v=%b %h expected v=1 %h", out_valid, dut_out(), snap);
        end
      end
      if (in_valid && in_ready) begin exp_q.push_back(ref_model(isum, iexp_max)); issued++; end
      if (out_valid && out_ready) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++; $display("[TB] FAIL rand_extra: got out_valid=1 expected no pending result");
        end else begin
          e = exp_q.pop_front();
          if (dut_out() !== e) begin fails++; $display("[TB] FAIL rand_data: got %h expected %h", dut_out(), e); end
        end
      end
      prev_stall = out_valid && !out_ready;
      snap = dut_out();
    end
    @(negedge clock);
    in_valid = 1'b0; out_ready = 1'b1;
    tests++;
    if (issued != 400 || exp_q.size() != 0) begin
      fails++; $display("[TB] FAIL rand_complete: got issued=%0d pending=%0d expected 400 0", issued, exp_q.size());
    end
  endtask

  task automatic test_reset_midflight();
    int   stale, lat;
    res_t got, e;
    logic [63:0] s;
    logic [10:0] ie;
    out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      in_valid = 1'b1; isum = rand_sum(); iexp_max = rand_exp();
    end
    @(negedge clock);
    in_valid = 1'b0;
    @(negedge clock);
    #1;
    tests++;
    if (out_valid !== 1'b1) begin fails++; $display("[TB] FAIL mid_loaded: got %b expected 1", out_valid); end
    #1 reset = 1'b1;
    #1;
    tests++;
    if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL mid_out_valid: got %b expected 0", out_valid); end
    tests++;
    if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL mid_in_ready: got %b expected 1", in_ready); end
    tests++;
    if (dut_out() !== res_t'(0)) begin fails++; $display("[TB] FAIL mid_outputs: got %h expected 0", dut_out()); end
    repeat (2) @(negedge clock);
    reset = 1'b0; out_ready = 1'b1;
    stale = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      #1;
      if (out_valid) stale++;
    end
    tests++;
    if (stale != 0) begin fails++; $display("[TB] FAIL mid_stale: got %0d results expected 0", stale); end
    s = rand_sum(); ie = rand_exp();
    e = ref_model(s, ie);
    send_and_wait(s, ie, got, lat);
    tests++;
    if (got !== e || lat != 3) begin
      fails++; $display("[TB] FAIL mid_recover: got %h lat %0d expected %h lat 3", got, lat, e);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fp_normalize_pipe.md
FP_NORMALIZE_PIPE -- requirements
Module: fp_normalize_pipe

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- EXP_W, 11, exponent width; matches the exponent-compare WIDTH.
- FRAC_W, 52, stored fraction width.
- SUM_W, 64, aligned signed sum width.
- The hidden-bit position is H = SUM_W-5 (bit 59).

REQ-002 Ports (name, direction, width, meaning), one per line; the block has one clock, and reset is asynchronous and active-high:
- clock, in, 1, rising-edge clock.
- reset, in, 1, asynchronous active-high reset.
- in_valid, in, 1, input transaction present.
- in_ready, out, 1, block accepts the input this cycle.
- iexp_max, in, EXP_W, common max exponent of the aligned operands.
- isum, in, SUM_W, two's-complement aligned mantissa sum.
- out_valid, out, 1, result present.
- out_ready, in, 1, downstream accepts the result.
- osign, out, 1, result sign.
- oexp, out, EXP_W, biased result exponent.
- ofrac, out, FRAC_W, result fraction, hidden bit removed.
- ozero, out, 1, result is zero.
- oovf, out, 1, overflow; result forced to infinity.
- ounf, out, 1, underflow; result flushed to zero.

Function
REQ-003 The input value SHALL be isum * 2^(iexp_max - H), relative to the biased exponent.
REQ-004 The block SHALL be a 3-stage pipeline, S1 -> S2 -> S3, with one valid flag per stage; the S3 registers drive all outputs directly.
REQ-005 Stage k SHALL load when stage k is empty or stage k advances in the same cycle; S3 advances on out_valid && out_ready.
REQ-006 in_ready SHALL be combinational: !S1_valid || S1 advances; an input transfers on in_valid && in_ready.
REQ-007 With out_ready held high, latency SHALL be exactly 3 cycles from the input transfer edge to out_valid, at a throughput of 1 result/cycle.
REQ-008 While out_valid && !out_ready, all outputs SHALL hold stable and no stage data SHALL be lost or duplicated.
REQ-009 S1 SHALL register:
- sign = isum[SUM_W-1];
- the magnitude |isum| as a SUM_W-bit unsigned value; -2^(SUM_W-1) SHALL yield magnitude 2^(SUM_W-1) without overflow;
- iexp_max.
REQ-010 S2 SHALL:
- compute the leading-one position p of the magnitude;
- left-shift the magnitude so bit p lands at bit SUM_W-1;
- compute e = iexp_max + (p - H) in signed EXP_W+2 bits;
- register the zero flag when the magnitude == 0.
REQ-011 S3 SHALL round to nearest, ties-to-even:
- lsb = normalized bit SUM_W-1-FRAC_W;
- guard = the next bit below lsb;
- sticky = OR of all remaining lower bits;
- increment when guard && (sticky || lsb).
REQ-012 A rounding carry out of the fraction SHALL give ofrac = 0 and e+1.
REQ-013 Zero: ozero=1, osign=0, oexp=0, ofrac=0, oovf=0, ounf=0.
REQ-014 Overflow: if the final e >= 2^EXP_W-1, then oexp = all ones, ofrac = 0, oovf = 1, and osign is kept.
REQ-015 Underflow: if the final e <= 0 and the input is nonzero, then oexp = 0, ofrac = 0, ounf = 1, ozero = 1, and osign is kept. There is no subnormal support.
REQ-016 Otherwise the block SHALL output oexp = e[EXP_W-1:0], ofrac = the rounded fraction, and all flags = 0.
REQ-017 Simultaneous S3 drain and S1 load SHALL both take effect in the same cycle.

Reset
REQ-018 Asserting reset SHALL immediately clear all stage valid flags and force out_valid=0, osign=0, oexp=0, ofrac=0, ozero=0, oovf=0, ounf=0.
REQ-019 in_ready SHALL be 1 while the pipeline is empty, including during reset.
REQ-020 Reset mid-operation SHALL discard all in-flight transactions; no result SHALL appear after reset deasserts.

Verification
REQ-021 Basic normalization:
- isum = 2^59, iexp_max = 1023, out_ready = 1 -> 3 cycles later out_valid = 1, osign = 0, oexp = 1023, ofrac = 0.
- isum = -(3*2^58), iexp_max = 1023 -> osign = 1, oexp = 1023, ofrac = 2^51.
REQ-022 Exponent adjustment:
- isum = 2^62, iexp_max = 1023 -> oexp = 1026.
- isum = 2^59 + 2^58, iexp_max = 1 (e = 1) -> normal output.
- isum = 2^58, iexp_max = 1 -> ounf = 1, ozero = 1, oexp = 0.
REQ-023 Rounding:
- isum = 2^59 + 2^6 (tie, lsb = 0) -> ofrac = 0.
- isum = 2^59 + 2^7 + 2^6 (tie, lsb = 1) -> ofrac = 2.
- isum = 2^60 - 1, iexp_max = 1023 -> carry out, oexp = 1024, ofrac = 0.
REQ-024 Limits:
- isum = 2^60, iexp_max = 2046 -> oovf = 1, oexp = 2047, ofrac = 0.
- isum = 0 -> ozero = 1 with all other fields 0.
- isum = -2^63, iexp_max = 1000 -> osign = 1, oexp = 1004, ofrac = 0.
REQ-025 Backpressure: issue 4 back-to-back inputs with out_ready = 0.
- in_ready SHALL drop after the third input is accepted and stay 0 while out_ready = 0.
- The outputs SHALL stay frozen.
- After out_ready = 1, all 4 results SHALL emerge in order, one per cycle.
REQ-026 Reset with 2 transactions in flight -> out_valid = 0 at once, in_ready = 1, and no stale output after release.
